// File: rtl/qsys_master.sv
// Avalon-MM read traffic generator: issues NUM_REQ header-tagged reads under an outstanding limit
// and checks the header of every returned beat.
module qsys_master #(
  parameter int unsigned              WIDTH           = 32,
  parameter logic [7:0]               ID              = 8'd0,
  parameter logic [7:0]               DST             = 8'd1,
  parameter int unsigned              ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR       = '0,
  parameter int unsigned              NUM_REQ         = 1000,
  parameter int unsigned              MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read,
  output logic                  write,
  output logic [WIDTH-1:0]      writedata,
  input  logic                  waitrequest,
  input  logic [WIDTH-1:0]      readdata,
  input  logic                  readdatavalid,
  output logic [31:0]           rsp_count,
  output logic [15:0]           err_count
);

  localparam int unsigned SeqW   = WIDTH - 16;
  localparam logic [31:0] NumReq = 32'(NUM_REQ);
  localparam logic [7:0]  MaxOut = 8'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       req_count_q, req_count_d;
  logic [SeqW-1:0]   seq_q, seq_d;
  logic [7:0]        outstanding_q, outstanding_d;
  logic [31:0]       rsp_count_q, rsp_count_d;
  logic [15:0]       err_count_q, err_count_d;

  logic accept;
  logic in_run;
  logic rsp_expected;
  logic rsp_unexpected;
  logic hdr_ok;
  logic err_inc;

  // Response payload is not checked, only the header bytes.
  logic unused_rsp_data;
  assign unused_rsp_data = ^readdata[SeqW-1:0];

  always_comb begin
    read      = (state_q == StIssue) && (outstanding_q < MaxOut) && (req_count_q < NumReq);
    write     = 1'b0;
    address   = BASE_ADDR;
    writedata = (state_q == StIssue) ? {ID, DST, seq_q} : '0;
    done      = (state_q == StDone);
    rsp_count = rsp_count_q;
    err_count = err_count_q;
  end

  always_comb begin
    accept         = read && !waitrequest;
    in_run         = (state_q == StIssue) || (state_q == StDrain);
    rsp_expected   = readdatavalid && in_run && (outstanding_q != 8'd0);
    rsp_unexpected = readdatavalid && !rsp_expected;
    hdr_ok         = (readdata[WIDTH-1 -: 8] == DST) && (readdata[WIDTH-9 -: 8] == ID);
    err_inc        = rsp_unexpected || (rsp_expected && !hdr_ok);
  end

  always_comb begin
    req_count_d   = req_count_q;
    seq_d         = seq_q;
    outstanding_d = outstanding_q;
    rsp_count_d   = rsp_count_q;
    err_count_d   = err_count_q;
    state_d       = state_q;

    if (accept) begin
      req_count_d = req_count_q + 32'd1;
      seq_d       = seq_q + SeqW'(1);
    end

    // Simultaneous accept and response leaves the count unchanged.
    unique case ({accept, rsp_expected})
      2'b10:   outstanding_d = outstanding_q + 8'd1;
      2'b01:   outstanding_d = outstanding_q - 8'd1;
      default: outstanding_d = outstanding_q;
    endcase

    if (rsp_expected) begin
      rsp_count_d = rsp_count_q + 32'd1;
    end
    if (err_inc && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end

    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: if (req_count_d == NumReq) state_d = StDrain;
      StDrain: if (outstanding_d == 8'd0) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      req_count_q   <= '0;
      seq_q         <= '0;
      outstanding_q <= '0;
      rsp_count_q   <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      req_count_q   <= req_count_d;
      seq_q         <= seq_d;
      outstanding_q <= outstanding_d;
      rsp_count_q   <= rsp_count_d;
      err_count_q   <= err_count_d;
    end
  end

endmodule
